// File: rtl/axis_frame_gen_pkg.sv
// Shared video package: FSM states, pattern codes and sizing helpers.
package axis_frame_gen_pkg;

  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned SEL_W       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  localparam logic [SEL_W-1:0] PAT_HRAMP   = 2'd0;
  localparam logic [SEL_W-1:0] PAT_VRAMP   = 2'd1;
  localparam logic [SEL_W-1:0] PAT_CHECKER = 2'd2;
  localparam logic [SEL_W-1:0] PAT_CONST   = 2'd3;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 32'd1) ? 32'($clog2(v)) : 32'd1;
  endfunction

endpackage

// File: rtl/axis_frame_gen_if.sv
// AXI-Stream video bus between the frame generator and its sink.
interface axis_frame_gen_if #(
  parameter int unsigned DATA_WIDTH = 10
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tuser;
  logic                  tlast;

  modport master (
    output tvalid,
    output tdata,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_pattern_lut.sv
// Combinational pixel generator: (x, y, pattern, constant) -> pixel value.
module axis_pattern_lut
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9
) (
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DATA_WIDTH-1:0] cval,
  output logic [DATA_WIDTH-1:0] pixel_c
);

  // Pattern select; coordinates are zero-extended so narrow counters still have a bit 3.
  always_comb begin
    pixel_c = '0;
    case (sel)
      PAT_HRAMP:   pixel_c = DATA_WIDTH'(32'(x));
      PAT_VRAMP:   pixel_c = DATA_WIDTH'(32'(y));
      PAT_CHECKER: pixel_c = ((((32'(x) ^ 32'(y)) >> 3) & 32'd1) != 32'd0) ? '1 : '0;
      PAT_CONST:   pixel_c = cval;
      default:     pixel_c = '0;
    endcase
  end

endmodule

// File: rtl/axis_frame_gen.sv
// Test-pattern video source emitting raster frames on an AXI-Stream master.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned H_BLANK    = 16,
  parameter int unsigned V_BLANK    = 64
) (
  input  logic                   pixel_clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [SEL_W-1:0]       pattern_sel,
  input  logic [DATA_WIDTH-1:0]  pattern_const,
  axis_frame_gen_if.master       m_axis,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   busy
);

  localparam int unsigned XW   = clog2_min1(IMG_WIDTH);
  localparam int unsigned YW   = clog2_min1(IMG_HEIGHT);
  localparam int unsigned BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int unsigned BW   = clog2_min1(BMAX);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [BW-1:0] H_LOAD = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] V_LOAD = BW'(V_BLANK - 1);

  state_e                 state;
  logic [XW-1:0]          x;
  logic [YW-1:0]          y;
  logic [BW-1:0]          bcnt;
  logic [SEL_W-1:0]       sel_q;
  logic [DATA_WIDTH-1:0]  const_q;
  logic                   tvalid_q;
  logic                   tuser_q;
  logic                   tlast_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   busy_q;

  logic                   beat_c;
  logic                   x_last_c;
  logic                   y_last_c;
  logic                   blank_done_c;
  logic                   start_c;
  logic                   load_c;
  logic [XW-1:0]          nx_c;
  logic [SEL_W-1:0]       lut_sel_c;
  logic [DATA_WIDTH-1:0]  lut_const_c;
  logic [DATA_WIDTH-1:0]  pixel_c;

  // Handshake and position decode for the pixel currently on the bus.
  assign beat_c       = tvalid_q & m_axis.tready;
  assign x_last_c     = (x == X_LAST);
  assign y_last_c     = (y == Y_LAST);
  assign blank_done_c = (bcnt == '0);
  assign start_c      = ((state == ST_IDLE) && enable) ||
                        ((state == ST_VBLANK) && blank_done_c && enable);

  // Column of the pixel to present next cycle; blanking states already hold the next line's start.
  assign nx_c        = ((state == ST_ACTIVE) && beat_c && !x_last_c) ? x + XW'(1) : x;
  assign lut_sel_c   = start_c ? pattern_sel : sel_q;
  assign lut_const_c = start_c ? pattern_const : const_q;

  // Output register refresh: on each accepted beat, during blanking, and at a start from IDLE.
  always_comb begin
    load_c = 1'b0;
    case (state)
      ST_IDLE:   load_c = enable;
      ST_ACTIVE: load_c = beat_c;
      default:   load_c = 1'b1;
    endcase
  end

  axis_pattern_lut #(
    .DATA_WIDTH (DATA_WIDTH),
    .XW         (XW),
    .YW         (YW)
  ) u_lut (
    .x       (nx_c),
    .y       (y),
    .sel     (lut_sel_c),
    .cval    (lut_const_c),
    .pixel_c (pixel_c)
  );

  // Raster FSM with registered stream outputs, frame counter and busy flag.
  always_ff @(posedge pixel_clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      bcnt        <= '0;
      sel_q       <= PAT_HRAMP;
      const_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (load_c) begin
        tdata_q <= pixel_c;
        tuser_q <= (nx_c == '0) && (y == '0);
        tlast_q <= (nx_c == X_LAST);
      end
      if (start_c) begin
        sel_q   <= pattern_sel;
        const_q <= pattern_const;
      end
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state    <= ST_ACTIVE;
            tvalid_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (beat_c) begin
            if (x_last_c) begin
              x        <= '0;
              tvalid_q <= 1'b0;
              if (y_last_c) begin
                y           <= '0;
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                bcnt        <= V_LOAD;
                state       <= ST_VBLANK;
              end else begin
                y     <= y + YW'(1);
                bcnt  <= H_LOAD;
                state <= ST_HBLANK;
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        ST_HBLANK: begin
          if (blank_done_c) begin
            state    <= ST_ACTIVE;
            tvalid_q <= 1'b1;
          end else begin
            bcnt <= bcnt - BW'(1);
          end
        end
        ST_VBLANK: begin
          if (blank_done_c) begin
            if (enable) begin
              state    <= ST_ACTIVE;
              tvalid_q <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            bcnt <= bcnt - BW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: 8x4 instance plus a 16x16 checkerboard instance.
module tb_axis_frame_gen;

  localparam int unsigned DW  = 10;
  localparam int unsigned AW  = 8;
  localparam int unsigned AH  = 4;
  localparam int unsigned BWD = 16;
  localparam int unsigned BHT = 16;
  localparam int unsigned HB  = 2;
  localparam int unsigned VB  = 3;
  localparam int CAP_BUDGET   = 6000;

  logic          clk;
  logic          resetn_a, resetn_b;
  logic          enable_a, enable_b;
  logic [1:0]    sel_a, sel_b;
  logic [DW-1:0] const_a, const_b;
  logic [15:0]   fc_a, fc_b;
  logic          busy_a, busy_b;
  logic          rdy;

  int errors;
  int checks;
  logic [15:0] exp_fc_a;

  logic [DW-1:0] cap_data[$];
  logic          cap_user[$];
  logic          cap_last[$];
  int            cap_gap[$];

  axis_frame_gen_if #(.DATA_WIDTH(DW)) if_a ();
  axis_frame_gen_if #(.DATA_WIDTH(DW)) if_b ();

  assign if_a.tready = rdy;
  assign if_b.tready = rdy;

  axis_frame_gen #(
    .DATA_WIDTH(DW), .IMG_WIDTH(AW), .IMG_HEIGHT(AH), .H_BLANK(HB), .V_BLANK(VB)
  ) u_dut (
    .pixel_clk(clk), .resetn(resetn_a), .enable(enable_a), .pattern_sel(sel_a),
    .pattern_const(const_a), .m_axis(if_a), .frame_cnt(fc_a), .busy(busy_a)
  );

  axis_frame_gen #(
    .DATA_WIDTH(DW), .IMG_WIDTH(BWD), .IMG_HEIGHT(BHT), .H_BLANK(HB), .V_BLANK(VB)
  ) u_ck (
    .pixel_clk(clk), .resetn(resetn_b), .enable(enable_b), .pattern_sel(sel_b),
    .pattern_const(const_b), .m_axis(if_b), .frame_cnt(fc_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference pixel from the pattern definitions (checkerboard = parity of 8x8 tile index).
  function automatic logic [DW-1:0] ref_pix(input int x, input int y, input logic [1:0] sel,
                                            input logic [DW-1:0] c);
    case (sel)
      2'd0:    return DW'(x % (1 << DW));
      2'd1:    return DW'(y % (1 << DW));
      2'd2:    return ((((x / 8) + (y / 8)) % 2) == 1) ? {DW{1'b1}} : {DW{1'b0}};
      default: return c;
    endcase
  endfunction

  // Record accepted beats, idle gaps before each beat and hold-rule breaches.
  task automatic capture(input bit which, input int nbeats, input int unsigned ready_pct,
                         input int drop_at, input int chg_at, input logic [1:0] chg_sel,
                         output int got, output int hold_viol);
    logic ov, ou, ol, pv, pr, pu, pl;
    logic [DW-1:0] od, pd;
    int idle;
    cap_data.delete(); cap_user.delete(); cap_last.delete(); cap_gap.delete();
    got = 0; hold_viol = 0; idle = 0;
    pv = 1'b0; pr = 1'b0; pu = 1'b0; pl = 1'b0; pd = '0;
    for (int cyc = 0; cyc < CAP_BUDGET && got < nbeats; cyc++) begin
      @(negedge clk);
      rdy = ($urandom_range(99) < ready_pct);
      ov = which ? if_b.tvalid : if_a.tvalid;
      od = which ? if_b.tdata  : if_a.tdata;
      ou = which ? if_b.tuser  : if_a.tuser;
      ol = which ? if_b.tlast  : if_a.tlast;
      if (pv && !pr && (ov !== 1'b1 || od !== pd || ou !== pu || ol !== pl)) hold_viol++;
      if (ov && rdy) begin
        cap_data.push_back(od); cap_user.push_back(ou); cap_last.push_back(ol);
        cap_gap.push_back(idle);
        idle = 0;
        if (got == drop_at) begin if (which) enable_b = 1'b0; else enable_a = 1'b0; end
        if (got == chg_at)  begin if (which) sel_b = chg_sel; else sel_a = chg_sel; end
        got++;
      end else if (!ov) begin
        idle++;
      end
      pv = ov; pr = rdy; pd = od; pu = ou; pl = ol;
    end
  endtask

  // Wait for busy to drop, counting idle (tvalid=0) busy cycles on the way.
  task automatic wait_idle(input bit which, output int vb, output bit to);
    vb = 0; to = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!(which ? busy_b : busy_a)) begin to = 1'b0; break; end
      if (!(which ? if_b.tvalid : if_a.tvalid)) vb++;
    end
  endtask

  task automatic test_reset();
    rdy = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    sel_a = 2'd0; sel_b = 2'd0; const_a = '0; const_b = '0;
    resetn_a = 1'b1; resetn_b = 1'b1;
    #1 resetn_a = 1'b0; resetn_b = 1'b0;
    #2;
    checks++; if (if_a.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", if_a.tvalid); end
    checks++; if (if_a.tuser !== 1'b0) begin errors++; $display("FAIL reset_tuser got=%b want=0", if_a.tuser); end
    checks++; if (if_a.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", if_a.tlast); end
    checks++; if (if_a.tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%h want=0", if_a.tdata); end
    checks++; if (fc_a !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got=%h want=0", fc_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
    checks++; if (if_b.tvalid !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_b got=%b%b want=00", if_b.tvalid, busy_b); end
    @(negedge clk); @(negedge clk);
    resetn_a = 1'b1; resetn_b = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (if_a.tvalid !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL idle_no_enable got=%b%b want=00", if_a.tvalid, busy_a); end
    exp_fc_a = 16'd0;
  endtask

  task automatic test_hramp();
    int got, hv, vbc; bit to;
    @(negedge clk);
    sel_a = 2'd0; const_a = DW'($urandom); enable_a = 1'b1; rdy = 1'b1;
    capture(0, 32, 100, 31, -1, 2'd0, got, hv);
    checks++; if (got != 32) begin errors++; $display("FAIL hramp_beats got=%0d want=32", got); end
    for (int i = 0; i < got; i++) begin
      int x, y;
      x = i % AW; y = i / AW;
      checks++; if (cap_data[i] !== ref_pix(x, y, 2'd0, const_a)) begin errors++; $display("FAIL hramp_data beat=%0d got=%h want=%h", i, cap_data[i], ref_pix(x, y, 2'd0, const_a)); end
      checks++; if (cap_user[i] !== (i == 0)) begin errors++; $display("FAIL hramp_tuser beat=%0d got=%b", i, cap_user[i]); end
      checks++; if (cap_last[i] !== (x == AW - 1)) begin errors++; $display("FAIL hramp_tlast beat=%0d got=%b", i, cap_last[i]); end
      if (x == 0 && y > 0) begin
        checks++; if (cap_gap[i] != HB) begin errors++; $display("FAIL hramp_hblank beat=%0d got=%0d want=%0d", i, cap_gap[i], HB); end
      end
    end
    exp_fc_a = exp_fc_a + 16'd1;
    wait_idle(0, vbc, to);
    checks++; if (to) begin errors++; $display("FAIL hramp_idle_timeout got=busy want=idle"); end
    checks++; if (vbc != VB) begin errors++; $display("FAIL hramp_vblank got=%0d want=%0d", vbc, VB); end
    checks++; if (fc_a !== exp_fc_a) begin errors++; $display("FAIL hramp_frame_cnt got=%0d want=%0d", fc_a, exp_fc_a); end
  endtask

  task automatic test_backpressure();
    int got, hv, vbc; bit to;
    for (int f = 0; f < 3; f++) begin
      logic [1:0] s; logic [DW-1:0] c;
      s = 2'($urandom_range(3)); c = DW'($urandom);
      @(negedge clk);
      sel_a = s; const_a = c; enable_a = 1'b1;
      capture(0, 32, 50, 0, 3, ~s, got, hv);
      checks++; if (got != 32) begin errors++; $display("FAIL bp_beats frame=%0d got=%0d want=32", f, got); end
      checks++; if (hv != 0) begin errors++; $display("FAIL bp_hold frame=%0d got=%0d want=0", f, hv); end
      for (int i = 0; i < got; i++) begin
        int x, y;
        x = i % AW; y = i / AW;
        checks++;
        if (cap_data[i] !== ref_pix(x, y, s, c) || cap_user[i] !== (i == 0) || cap_last[i] !== (x == AW - 1)) begin
          errors++;
          $display("FAIL bp_beat frame=%0d beat=%0d got=%h/%b/%b want=%h/%b/%b", f, i, cap_data[i], cap_user[i], cap_last[i], ref_pix(x, y, s, c), (i == 0), (x == AW - 1));
        end
        if (x == 0 && y > 0) begin
          checks++; if (cap_gap[i] != HB) begin errors++; $display("FAIL bp_hblank beat=%0d got=%0d want=%0d", i, cap_gap[i], HB); end
        end
      end
      exp_fc_a = exp_fc_a + 16'd1;
      wait_idle(0, vbc, to);
      checks++; if (to || fc_a !== exp_fc_a) begin errors++; $display("FAIL bp_frame_cnt got=%0d want=%0d", fc_a, exp_fc_a); end
    end
  endtask

  task automatic test_enable_drop();
    int got, hv, vbc; bit to;
    @(negedge clk);
    sel_a = 2'd1; const_a = '0; enable_a = 1'b1; rdy = 1'b1;
    capture(0, 32, 100, 5, -1, 2'd0, got, hv);
    checks++; if (got != 32) begin errors++; $display("FAIL drop_beats got=%0d want=32", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if (cap_data[i] !== ref_pix(i % AW, i / AW, 2'd1, '0)) begin errors++; $display("FAIL drop_data beat=%0d got=%h want=%h", i, cap_data[i], ref_pix(i % AW, i / AW, 2'd1, '0)); end
    end
    exp_fc_a = exp_fc_a + 16'd1;
    wait_idle(0, vbc, to);
    checks++; if (to) begin errors++; $display("FAIL drop_idle_timeout got=busy want=idle"); end
    checks++; if (vbc != VB) begin errors++; $display("FAIL drop_vblank got=%0d want=%0d", vbc, VB); end
    repeat (4) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || if_a.tvalid !== 1'b0) begin errors++; $display("FAIL drop_stays_idle got=%b%b want=00", busy_a, if_a.tvalid); end
    checks++; if (fc_a !== exp_fc_a) begin errors++; $display("FAIL drop_frame_cnt got=%0d want=%0d", fc_a, exp_fc_a); end
  endtask

  task automatic test_back_to_back();
    int got, hv, vbc; bit to;
    logic [DW-1:0] c;
    c = DW'($urandom);
    @(negedge clk);
    sel_a = 2'd3; const_a = c; enable_a = 1'b1; rdy = 1'b1;
    capture(0, 64, 100, 63, -1, 2'd0, got, hv);
    checks++; if (got != 64) begin errors++; $display("FAIL b2b_beats got=%0d want=64", got); end
    for (int i = 0; i < got; i++) begin
      int x, y;
      x = i % AW; y = (i / AW) % AH;
      checks++;
      if (cap_data[i] !== c || cap_user[i] !== (x == 0 && y == 0) || cap_last[i] !== (x == AW - 1)) begin
        errors++; $display("FAIL b2b_beat beat=%0d got=%h/%b/%b want=%h/%b/%b", i, cap_data[i], cap_user[i], cap_last[i], c, (x == 0 && y == 0), (x == AW - 1));
      end
    end
    if (got == 64) begin
      checks++; if (cap_gap[32] != VB) begin errors++; $display("FAIL b2b_frame_gap got=%0d want=%0d", cap_gap[32], VB); end
    end
    exp_fc_a = exp_fc_a + 16'd2;
    wait_idle(0, vbc, to);
    checks++; if (to || fc_a !== exp_fc_a) begin errors++; $display("FAIL b2b_frame_cnt got=%0d want=%0d", fc_a, exp_fc_a); end
  endtask

  task automatic test_checker();
    int got, hv, vbc; bit to;
    @(negedge clk);
    sel_b = 2'd2; const_b = DW'($urandom); enable_b = 1'b1;
    capture(1, 512, 50, 300, 100, 2'd0, got, hv);
    checks++; if (got != 512) begin errors++; $display("FAIL ck_beats got=%0d want=512", got); end
    checks++; if (hv != 0) begin errors++; $display("FAIL ck_hold got=%0d want=0", hv); end
    for (int i = 0; i < got; i++) begin
      int x, y;
      logic [1:0] s;
      x = i % BWD; y = (i / BWD) % BHT;
      s = (i < BWD * BHT) ? 2'd2 : 2'd0;
      checks++;
      if (cap_data[i] !== ref_pix(x, y, s, const_b) || cap_user[i] !== (x == 0 && y == 0) || cap_last[i] !== (x == BWD - 1)) begin
        errors++; $display("FAIL ck_beat beat=%0d got=%h/%b/%b want=%h/%b/%b", i, cap_data[i], cap_user[i], cap_last[i], ref_pix(x, y, s, const_b), (x == 0 && y == 0), (x == BWD - 1));
      end
    end
    wait_idle(1, vbc, to);
    checks++; if (to || fc_b !== 16'd2) begin errors++; $display("FAIL ck_frame_cnt got=%0d want=2", fc_b); end
  endtask

  task automatic test_reset_mid();
    int got, hv, vbc; bit to;
    @(negedge clk);
    sel_a = 2'd0; enable_a = 1'b1; rdy = 1'b1;
    capture(0, 12, 100, -1, -1, 2'd0, got, hv);
    checks++; if (got != 12 || if_a.tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%0d/%b want=12/1", got, if_a.tvalid); end
    #1 resetn_a = 1'b0;
    #1;
    checks++; if (if_a.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got=%b want=0", if_a.tvalid); end
    checks++; if (busy_a !== 1'b0 || fc_a !== 16'd0 || if_a.tdata !== '0) begin errors++; $display("FAIL rstmid_state got=%b/%0d/%h want=0/0/0", busy_a, fc_a, if_a.tdata); end
    exp_fc_a = 16'd0;
    @(negedge clk);
    resetn_a = 1'b1;
    capture(0, 32, 100, 31, -1, 2'd0, got, hv);
    checks++; if (got != 32) begin errors++; $display("FAIL rstmid_beats got=%0d want=32", got); end
    if (got > 0) begin
      checks++; if (cap_user[0] !== 1'b1 || cap_data[0] !== '0) begin errors++; $display("FAIL rstmid_first got=%b/%h want=1/000", cap_user[0], cap_data[0]); end
    end
    for (int i = 1; i < got; i++) begin
      checks++; if (cap_data[i] !== ref_pix(i % AW, i / AW, 2'd0, '0) || cap_user[i] !== 1'b0) begin errors++; $display("FAIL rstmid_data beat=%0d got=%h/%b want=%h/0", i, cap_data[i], cap_user[i], ref_pix(i % AW, i / AW, 2'd0, '0)); end
    end
    exp_fc_a = exp_fc_a + 16'd1;
    wait_idle(0, vbc, to);
    checks++; if (to || fc_a !== exp_fc_a) begin errors++; $display("FAIL rstmid_frame_cnt got=%0d want=%0d", fc_a, exp_fc_a); end
  endtask

  task automatic test_frame_cnt_wrap();
    int got, hv, vbc; bit to;
    @(negedge clk);
    force u_dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release u_dut.frame_cnt_q;
    @(negedge clk);
    checks++; if (fc_a !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h want=ffff", fc_a); end
    sel_a = 2'($urandom_range(3)); enable_a = 1'b1; rdy = 1'b1;
    capture(0, 32, 100, 31, -1, 2'd0, got, hv);
    wait_idle(0, vbc, to);
    checks++; if (to || fc_a !== 16'h0000) begin errors++; $display("FAIL wrap_frame_cnt got=%h want=0000", fc_a); end
  endtask

  initial begin
    errors = 0; checks = 0; exp_fc_a = 16'd0;
    test_reset();
    test_hramp();
    test_backpressure();
    test_enable_drop();
    test_back_to_back();
    test_checker();
    test_reset_mid();
    test_frame_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
